// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the RV32I control path: FSM states, major opcodes and
// the 5-bit aluop classes consumed by the ALU control.
package multicycle_control_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [4:0] ALU_R = 5'b01100;
  localparam logic [4:0] ALU_I = 5'b00100;
  localparam logic [4:0] ALU_S = 5'b01000;
  localparam logic [4:0] ALU_L = 5'b00000;
  localparam logic [4:0] ALU_B = 5'b11000;

  function automatic logic is_mem_wait_state(input logic [3:0] st);
    return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Saturating memory-wait counter; flags when the wait has reached TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic wait_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (wait_i && !expired_o)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables; memory states are bounded by a wait timer.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       irwrite_o,
  output logic       pcwrite_o,
  output logic       pcbranch_o,
  output logic       iord_o,
  output logic       regwrite_o,
  output logic       alusrc_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       memtoreg_o,
  output logic       branch_o,
  output logic [4:0] aluop_o,
  output logic       illegal_o,
  output logic       timeout_o,
  output logic [3:0] state_o
);

  logic [3:0] state_q, state_d;
  logic       is_store_q, is_store_d;
  logic       in_wait, expired, timeout, illegal;

  assign in_wait = is_mem_wait_state(state_q);
  assign timeout = in_wait && !mem_ready_i && expired;

  // A timeout in FETCH re-enters FETCH, so it must also restart the count.
  mem_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  ((state_d != state_q) || timeout),
    .wait_i   (in_wait && !mem_ready_i),
    .expired_o(expired)
  );

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        is_store_d = (opcode_i == OP_S);
        case (opcode_i)
          OP_R:       state_d = S_EXEC_R;
          OP_I:       state_d = S_EXEC_I;
          OP_L, OP_S: state_d = S_MEM_ADDR;
          OP_B:       state_d = S_BRANCH;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready_i) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
    if (timeout)
      state_d = S_FETCH;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  always_comb begin
    irwrite_o  = 1'b0;
    pcwrite_o  = 1'b0;
    pcbranch_o = 1'b0;
    iord_o     = 1'b0;
    regwrite_o = 1'b0;
    alusrc_o   = 1'b0;
    memread_o  = 1'b0;
    memwrite_o = 1'b0;
    memtoreg_o = 1'b0;
    branch_o   = 1'b0;
    aluop_o    = '0;
    illegal_o  = 1'b0;
    timeout_o  = 1'b0;
    state_o    = '0;
    if (!rst_i) begin
      state_o   = state_q;
      illegal_o = illegal;
      timeout_o = timeout;
      case (state_q)
        S_FETCH: begin
          memread_o = 1'b1;
          irwrite_o = mem_ready_i;
          pcwrite_o = mem_ready_i;
        end
        S_EXEC_R: aluop_o = ALU_R;
        S_EXEC_I: begin
          alusrc_o = 1'b1;
          aluop_o  = ALU_I;
        end
        S_MEM_ADDR: begin
          alusrc_o = 1'b1;
          aluop_o  = ALU_L;
        end
        S_MEM_RD: begin
          memread_o = 1'b1;
          iord_o    = 1'b1;
        end
        S_MEM_WR: begin
          memwrite_o = 1'b1;
          iord_o     = 1'b1;
          aluop_o    = ALU_S;
        end
        S_WB_ALU: regwrite_o = 1'b1;
        S_WB_MEM: begin
          regwrite_o = 1'b1;
          memtoreg_o = 1'b1;
        end
        S_BRANCH: begin
          branch_o   = 1'b1;
          aluop_o    = ALU_B;
          pcbranch_o = zero_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues hand-computed
// per-cycle output vectors, the monitor compares them against the DUT.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] opcode_i = '0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       irwrite_o, pcwrite_o, pcbranch_o, iord_o, regwrite_o, alusrc_o;
  logic       memread_o, memwrite_o, memtoreg_o, branch_o, illegal_o, timeout_o;
  logic [4:0] aluop_o;
  logic [3:0] state_o;

  multicycle_control #(
    .TIMEOUT(15),
    .CNT_W  (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .opcode_i   (opcode_i),
    .zero_i     (zero_i),
    .mem_ready_i(mem_ready_i),
    .irwrite_o  (irwrite_o),
    .pcwrite_o  (pcwrite_o),
    .pcbranch_o (pcbranch_o),
    .iord_o     (iord_o),
    .regwrite_o (regwrite_o),
    .alusrc_o   (alusrc_o),
    .memread_o  (memread_o),
    .memwrite_o (memwrite_o),
    .memtoreg_o (memtoreg_o),
    .branch_o   (branch_o),
    .aluop_o    (aluop_o),
    .illegal_o  (illegal_o),
    .timeout_o  (timeout_o),
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;

  // ctl bit order: irwrite pcwrite pcbranch iord regwrite alusrc memread memwrite memtoreg branch
  localparam logic [9:0] C0    = 10'b0000000000;
  localparam logic [9:0] C_FW  = 10'b0000001000;
  localparam logic [9:0] C_FR  = 10'b1100001000;
  localparam logic [9:0] C_ALI = 10'b0000010000;
  localparam logic [9:0] C_RD  = 10'b0001001000;
  localparam logic [9:0] C_WR  = 10'b0001000100;
  localparam logic [9:0] C_WBA = 10'b0000100000;
  localparam logic [9:0] C_WBM = 10'b0000100010;
  localparam logic [9:0] C_BT  = 10'b0010000001;
  localparam logic [9:0] C_BN  = 10'b0000000001;

  typedef struct {
    string       name;
    logic [20:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  wire [20:0] actual = {irwrite_o, pcwrite_o, pcbranch_o, iord_o, regwrite_o, alusrc_o,
                        memread_o, memwrite_o, memtoreg_o, branch_o, aluop_o,
                        illegal_o, timeout_o, state_o};

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (actual !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b alu=%b ill=%b to=%b st=%0d, expected ctl=%b alu=%b ill=%b to=%b st=%0d",
                 e.name, actual[20:11], actual[10:6], actual[5], actual[4], actual[3:0],
                 e.exp[20:11], e.exp[10:6], e.exp[5], e.exp[4], e.exp[3:0]);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic rdy, input logic [6:0] op,
                      input logic z, input logic [3:0] st, input logic [9:0] ctl,
                      input logic [4:0] alu, input logic ill, input logic to);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i       = rst;
    mem_ready_i = rdy;
    opcode_i    = op;
    zero_i      = z;
    e.name      = nm;
    e.exp       = {ctl, alu, ill, to, st};
    q.push_back(e);
  endtask

  initial begin
    step("reset0", 1, 1, OP_R, 0, 4'd0, C0, 5'b0, 0, 0);
    step("reset1", 1, 1, OP_R, 1, 4'd0, C0, 5'b0, 0, 0);

    // R-type, memory always ready: 0,1,2,7
    step("r.fetch",  0, 1, OP_R, 0, 4'd0, C_FR,  5'b0,  0, 0);
    step("r.decode", 0, 1, OP_R, 0, 4'd1, C0,    5'b0,  0, 0);
    step("r.exec",   0, 1, OP_R, 0, 4'd2, C0,    ALU_R, 0, 0);
    step("r.wb",     0, 1, OP_R, 0, 4'd7, C_WBA, 5'b0,  0, 0);

    // I-type
    step("i.fetch",  0, 1, OP_I, 0, 4'd0, C_FR,  5'b0,  0, 0);
    step("i.decode", 0, 1, OP_I, 0, 4'd1, C0,    5'b0,  0, 0);
    step("i.exec",   0, 1, OP_I, 0, 4'd3, C_ALI, ALU_I, 0, 0);
    step("i.wb",     0, 1, OP_I, 0, 4'd7, C_WBA, 5'b0,  0, 0);

    // Load, 2 fetch waits, 3 read waits: 10 cycles
    step("ld.fwait0", 0, 0, OP_L, 0, 4'd0, C_FW,  5'b0, 0, 0);
    step("ld.fwait1", 0, 0, OP_L, 0, 4'd0, C_FW,  5'b0, 0, 0);
    step("ld.fetch",  0, 1, OP_L, 0, 4'd0, C_FR,  5'b0, 0, 0);
    step("ld.decode", 0, 1, OP_L, 0, 4'd1, C0,    5'b0, 0, 0);
    step("ld.addr",   0, 1, OP_S, 0, 4'd4, C_ALI, ALU_L, 0, 0);
    for (int i = 0; i < 3; i++)
      step("ld.rwait", 0, 0, OP_S, 0, 4'd5, C_RD, 5'b0, 0, 0);
    step("ld.read",   0, 1, OP_S, 0, 4'd5, C_RD,  5'b0, 0, 0);
    step("ld.wb",     0, 1, OP_S, 0, 4'd8, C_WBM, 5'b0, 0, 0);

    // Branch taken then not taken
    step("bt.fetch",  0, 1, OP_B, 1, 4'd0, C_FR, 5'b0,  0, 0);
    step("bt.decode", 0, 1, OP_B, 1, 4'd1, C0,   5'b0,  0, 0);
    step("bt.branch", 0, 1, OP_B, 1, 4'd9, C_BT, ALU_B, 0, 0);
    step("bn.fetch",  0, 1, OP_B, 0, 4'd0, C_FR, 5'b0,  0, 0);
    step("bn.decode", 0, 1, OP_B, 0, 4'd1, C0,   5'b0,  0, 0);
    step("bn.branch", 0, 1, OP_B, 0, 4'd9, C_BN, ALU_B, 0, 0);

    // Unsupported opcode
    step("ill.fetch",  0, 1, 7'h7F, 0, 4'd0, C_FR, 5'b0, 0, 0);
    step("ill.decode", 0, 1, 7'h7F, 0, 4'd1, C0,   5'b0, 1, 0);

    // Store with memory never ready; opcode changes after DECODE are ignored
    step("st.fetch",  0, 1, OP_S, 0, 4'd0, C_FR,  5'b0,  0, 0);
    step("st.decode", 0, 1, OP_S, 0, 4'd1, C0,    5'b0,  0, 0);
    step("st.addr",   0, 0, OP_L, 0, 4'd4, C_ALI, ALU_L, 0, 0);
    for (int i = 0; i < 15; i++)
      step("st.wait", 0, 0, OP_L, 0, 4'd6, C_WR, ALU_S, 0, 0);
    step("st.timeout", 0, 0, OP_L, 0, 4'd6, C_WR, ALU_S, 0, 1);

    // Same store, ready arrives on the cycle the timeout would fire
    step("st2.fetch",  0, 1, OP_S, 0, 4'd0, C_FR,  5'b0,  0, 0);
    step("st2.decode", 0, 1, OP_S, 0, 4'd1, C0,    5'b0,  0, 0);
    step("st2.addr",   0, 0, OP_R, 0, 4'd4, C_ALI, ALU_L, 0, 0);
    for (int i = 0; i < 15; i++)
      step("st2.wait", 0, 0, OP_R, 0, 4'd6, C_WR, ALU_S, 0, 0);
    step("st2.ready_wins", 0, 1, OP_R, 0, 4'd6, C_WR, ALU_S, 0, 0);

    // Fetch timeout, then the counter restarts
    for (int i = 0; i < 15; i++)
      step("f.wait", 0, 0, OP_R, 0, 4'd0, C_FW, 5'b0, 0, 0);
    step("f.timeout",  0, 0, OP_R, 0, 4'd0, C_FW, 5'b0, 0, 1);
    step("f.restart",  0, 0, OP_R, 0, 4'd0, C_FW, 5'b0, 0, 0);

    // Reset during MEM_WR with memory ready
    step("rs.fetch",  0, 1, OP_S, 0, 4'd0, C_FR,  5'b0,  0, 0);
    step("rs.decode", 0, 1, OP_S, 0, 4'd1, C0,    5'b0,  0, 0);
    step("rs.addr",   0, 1, OP_S, 0, 4'd4, C_ALI, ALU_L, 0, 0);
    step("rs.reset",  1, 1, OP_S, 0, 4'd0, C0,    5'b0,  0, 0);
    step("rs.after",  0, 0, OP_S, 0, 4'd0, C_FW,  5'b0,  0, 0);
    step("rs.fetch2", 0, 1, OP_R, 0, 4'd0, C_FR,  5'b0,  0, 0);

    repeat (3) @(negedge clk_i);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
